re_name_commit: RTL

- Commit-side counterpart of the issue-stage register renamer.
- Strips the rename (name) bit from committing destination registers and returns architectural addresses.
- Maintains the committed per-register name-bit tables (GPR and FPR), which the renamer restores from on a flush.
- Counts in-flight writers per architectural register. Raises an issue hazard when a third writer would reuse a name still owned by an uncommitted instruction.

---
 rtl/re_name_commit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/re_name_commit.sv
// Commit-side rename bookkeeping. It strips the name bit from retiring destinations,
// keeps the committed name-bit tables and counts in-flight writers for the issue hazard.
module re_name_commit #(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned CNT_W           = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         flush_unissued_instr_i,
  input  logic                         issue_valid_i,
  input  logic                         issue_ack_i,
  input  logic [5:0]                   issue_rd_i,
  input  logic                         issue_rd_fpr_i,
  output logic                         issue_hazard_o,
  input  logic [NR_COMMIT_PORTS-1:0]   commit_valid_i,
  input  logic [NR_COMMIT_PORTS-1:0]   commit_ack_i,
  input  logic [NR_COMMIT_PORTS*6-1:0] commit_rd_i,
  input  logic [NR_COMMIT_PORTS-1:0]   commit_rd_fpr_i,
  output logic [NR_COMMIT_PORTS*5-1:0] commit_arch_rd_o,
  output logic [31:0]                  committed_gpr_o,
  output logic [31:0]                  committed_fpr_o,
  output logic                         underflow_o
);

  localparam int CntMax = (1 << CNT_W) - 1;

  typedef logic [CNT_W-1:0] cnt_t;

  cnt_t        cnt_gpr_q [32];
  cnt_t        cnt_gpr_d [32];
  cnt_t        cnt_fpr_q [32];
  cnt_t        cnt_fpr_d [32];
  logic [31:0] tbl_gpr_q, tbl_gpr_d;
  logic [31:0] tbl_fpr_q, tbl_fpr_d;
  logic        underflow_q, underflow_d;

  logic [NR_COMMIT_PORTS-1:0] retire;
  logic [4:0]                 issue_arch;
  logic                       issue_inc;
  logic                       issue_name_unused;
  cnt_t                       issue_cnt;

  assign retire            = commit_valid_i & commit_ack_i;
  assign issue_arch        = issue_rd_i[4:0];
  // The name bit only matters on the issue side; here only the architectural index is used.
  assign issue_name_unused = issue_rd_i[5];
  assign issue_inc         = issue_ack_i && !flush_unissued_instr_i &&
                             (issue_rd_fpr_i || (issue_arch != 5'd0));

  // Returns {underflow, new_count}: net change applied once, then clamped to [0, CntMax].
  function automatic logic [CNT_W:0] cnt_update(cnt_t cnt, logic inc, int unsigned dec);
    int net;
    net = int'(cnt) + int'(inc) - int'(dec);
    if (net < 0) return {1'b1, cnt_t'(0)};
    if (net > CntMax) return {1'b0, cnt_t'(CntMax)};
    return {1'b0, cnt_t'(net)};
  endfunction

  always_comb begin
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      commit_arch_rd_o[p*5 +: 5] = commit_rd_i[p*6 +: 5];
    end
  end

  always_comb begin
    int unsigned      dec_g;
    int unsigned      dec_f;
    logic [CNT_W:0]   res_g;
    logic [CNT_W:0]   res_f;
    dec_g       = 0;
    dec_f       = 0;
    res_g       = '0;
    res_f       = '0;
    cnt_gpr_d   = cnt_gpr_q;
    cnt_fpr_d   = cnt_fpr_q;
    underflow_d = underflow_q;
    for (int r = 0; r < 32; r++) begin
      dec_g = 0;
      dec_f = 0;
      for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
        if (retire[p] && (commit_rd_i[p*6 +: 5] == 5'(r))) begin
          if (commit_rd_fpr_i[p]) dec_f++;
          else                    dec_g++;
        end
      end
      res_g = cnt_update(cnt_gpr_q[r], issue_inc && !issue_rd_fpr_i && (issue_arch == 5'(r)),
                         dec_g);
      res_f = cnt_update(cnt_fpr_q[r], issue_inc && issue_rd_fpr_i && (issue_arch == 5'(r)),
                         dec_f);
      // x0 has no real writers, so its counter never moves and never underflows.
      if (r != 0) begin
        cnt_gpr_d[r] = res_g[CNT_W-1:0];
        underflow_d  = underflow_d | res_g[CNT_W];
      end
      cnt_fpr_d[r] = res_f[CNT_W-1:0];
      underflow_d  = underflow_d | res_f[CNT_W];
    end
    if (flush_i) begin
      for (int r = 0; r < 32; r++) begin
        cnt_gpr_d[r] = '0;
        cnt_fpr_d[r] = '0;
      end
      underflow_d = underflow_q;
    end
  end

  // Ascending port order lets the youngest retiring port win on a shared entry.
  always_comb begin
    tbl_gpr_d = tbl_gpr_q;
    tbl_fpr_d = tbl_fpr_q;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (retire[p]) begin
        if (commit_rd_fpr_i[p]) tbl_fpr_d[commit_rd_i[p*6 +: 5]] = commit_rd_i[p*6+5];
        else                    tbl_gpr_d[commit_rd_i[p*6 +: 5]] = commit_rd_i[p*6+5];
      end
    end
    tbl_gpr_d[0] = 1'b0;
  end

  always_comb begin
    issue_cnt      = issue_rd_fpr_i ? cnt_fpr_q[issue_arch] : cnt_gpr_q[issue_arch];
    issue_hazard_o = issue_valid_i && (issue_rd_fpr_i || (issue_arch != 5'd0)) &&
                     (int'(issue_cnt) >= 2);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < 32; r++) begin
        cnt_gpr_q[r] <= '0;
        cnt_fpr_q[r] <= '0;
      end
      tbl_gpr_q   <= '0;
      tbl_fpr_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      cnt_gpr_q   <= cnt_gpr_d;
      cnt_fpr_q   <= cnt_fpr_d;
      tbl_gpr_q   <= tbl_gpr_d;
      tbl_fpr_q   <= tbl_fpr_d;
      underflow_q <= underflow_d;
    end
  end

  assign committed_gpr_o = tbl_gpr_q;
  assign committed_fpr_o = tbl_fpr_q;
  assign underflow_o     = underflow_q;

endmodule
